// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer.
package pipe_pkg;

  // Default data word width.
  localparam int unsigned DataWidth = 32;

  // Buffer occupancy states; the encoding doubles as the Count output.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/dff_en_sync.sv
// WIDTH-bit register with load enable and synchronous active-low clear.
module dff_en_sync #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Clear dominates; otherwise load when enabled.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid_buf_32.sv
// Two-entry skid buffer: registered In_Ready, one cycle latency, full throughput.
module pipe_skid_buf_32
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Flush,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Data,
  output logic             In_Ready,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Data,
  input  logic             Out_Ready,
  output logic [1:0]       Count
);

  sb_state_e        state_q, state_d;
  logic             in_fire, out_fire;
  logic             m_en, m_from_skid, s_en;
  logic [WIDTH-1:0] m_d, m_q, s_q;

  // Handshake flags are decoded from state flops only, so no input reaches them.
  always_comb begin
    In_Ready  = (state_q != SB_FULL);
    Out_Valid = (state_q != SB_EMPTY);
    in_fire   = In_Valid & In_Ready;
    out_fire  = Out_Valid & Out_Ready;
  end

  assign Out_Data = m_q;
  assign Count    = state_q;

  // Next-state and register-enable decode; a flush discards both handshakes.
  always_comb begin
    state_d     = state_q;
    m_en        = 1'b0;
    m_from_skid = 1'b0;
    s_en        = 1'b0;
    if (Flush) begin
      state_d = SB_EMPTY;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (in_fire) begin
            state_d = SB_ONE;
            m_en    = 1'b1;
          end
        end
        SB_ONE: begin
          if (in_fire && out_fire) begin
            m_en = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled on the accepting cycle: park the word in S.
            state_d = SB_FULL;
            s_en    = 1'b1;
          end else if (out_fire) begin
            state_d = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (out_fire) begin
            state_d     = SB_ONE;
            m_en        = 1'b1;
            m_from_skid = 1'b1;
          end
        end
        default: state_d = SB_EMPTY;  // illegal encoding recovers
      endcase
    end
  end

  assign m_d = m_from_skid ? s_q : In_Data;

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q <= SB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  dff_en_sync #(
    .WIDTH(WIDTH)
  ) u_main (
    .clk_i (Clk),
    .clr_ni(Clrn),
    .en_i  (m_en),
    .d_i   (m_d),
    .q_o   (m_q)
  );

  dff_en_sync #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i (Clk),
    .clr_ni(Clrn),
    .en_i  (s_en),
    .d_i   (In_Data),
    .q_o   (s_q)
  );

endmodule

// File: tb/tb_pipe_skid_buf_32.sv
// Self-checking bench for pipe_skid_buf_32: queue model plus directed literals.
module tb_pipe_skid_buf_32;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Clrn, Flush, In_Valid, Out_Ready;
  logic [W-1:0] In_Data;
  logic         In_Ready, Out_Valid;
  logic [W-1:0] Out_Data;
  logic [1:0]   Count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: FIFO of accepted words (capacity 2) and the last word seen at the head.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;

  pipe_skid_buf_32 dut (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .Flush    (Flush),
    .In_Valid (In_Valid),
    .In_Data  (In_Data),
    .In_Ready (In_Ready),
    .Out_Valid(Out_Valid),
    .Out_Data (Out_Data),
    .Out_Ready(Out_Ready),
    .Count    (Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs seen at each rising edge.
  always @(posedge Clk) begin
    bit m_in_fire, m_out_fire;
    m_in_fire  = In_Valid && (mq.size() < 2);
    m_out_fire = Out_Ready && (mq.size() > 0);
    if (!Clrn) begin
      mq.delete();
      m_last = '0;
    end else if (Flush) begin
      mq.delete();
    end else begin
      if (m_out_fire) void'(mq.pop_front());
      if (m_in_fire) mq.push_back(In_Data);
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Compare all outputs against the model every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_out_valid", W'(Out_Valid), W'(mq.size() > 0));
      chk("model_in_ready", W'(In_Ready), W'(mq.size() < 2));
      chk("model_count", W'(Count), W'(mq.size()));
      chk("model_out_data", Out_Data, (mq.size() > 0) ? mq[0] : m_last);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    In_Valid  = v;
    In_Data   = d;
    Out_Ready = r;
    Flush     = f;
  endtask

  initial begin
    Clrn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      @(negedge Clk);
    end
    chk_en = 1'b1;
    chk("rst_out_valid", W'(Out_Valid), 0);
    chk("rst_in_ready", W'(In_Ready), 1);
    chk("rst_count", W'(Count), 0);
    chk("rst_out_data", Out_Data, 0);
    Clrn = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge Clk);

    // Streaming: each word appears one cycle after acceptance.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      @(negedge Clk);
      chk("stream_data", Out_Data, W'(i));
      chk("stream_count", W'(Count), 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    chk("stream_drain_count", W'(Count), 0);
    chk("stream_hold_data", Out_Data, 32'h8);

    // Stall: 0xB goes into the skid register.
    drive(1'b1, 32'hA, 1'b1, 1'b0);
    @(negedge Clk);
    chk("stall_a_data", Out_Data, 32'hA);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    @(negedge Clk);
    chk("stall_count", W'(Count), 2);
    chk("stall_in_ready", W'(In_Ready), 0);

    // Full hold: offered word is ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
      @(negedge Clk);
      chk("hold_data", Out_Data, 32'hA);
      chk("hold_count", W'(Count), 2);
    end

    // Release: 0xA leaves, then 0xB.
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    chk("release_b_data", Out_Data, 32'hB);
    chk("release_in_ready", W'(In_Ready), 1);
    chk("release_count", W'(Count), 1);
    @(negedge Clk);
    chk("release_empty", W'(Count), 0);

    // Flush from FULL with both handshakes attempted.
    drive(1'b1, 32'h21, 1'b0, 1'b0);
    @(negedge Clk);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    @(negedge Clk);
    chk("preflush_count", W'(Count), 2);
    drive(1'b1, 32'h33, 1'b1, 1'b1);
    @(negedge Clk);
    chk("flush_count", W'(Count), 0);
    chk("flush_out_valid", W'(Out_Valid), 0);
    chk("flush_m_hold", Out_Data, 32'h21);
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    @(negedge Clk);
    chk("postflush_data", Out_Data, 32'h55);
    chk("postflush_count", W'(Count), 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    chk("postflush_empty", W'(Out_Valid), 0);

    // Flush in ONE with in_fire: the offered word must be discarded.
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    @(negedge Clk);
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    @(negedge Clk);
    chk("flush_one_count", W'(Count), 0);
    chk("flush_one_data", Out_Data, 32'h66);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    chk("flush_one_stays_empty", W'(Out_Valid), 0);

    // Random soak; the compare process checks ordering and occupancy every cycle.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
      Clrn = ($urandom_range(0, 499) != 0);
      @(negedge Clk);
    end

    // Reset mid-transfer.
    Clrn = 1'b1;
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b0;
    @(negedge Clk);
    chk("midrst_count", W'(Count), 0);
    chk("midrst_data", Out_Data, 0);
    chk("midrst_in_ready", W'(In_Ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buf_32.md
# pipe_skid_buf_32

Two-entry skid buffer with valid/ready handshakes on both sides. It sits between two pipeline stages and replaces a bare enable-gated stage register. The upstream side sees a fully registered `In_Ready`, so the downstream stall (`Out_Ready`) never reaches the upstream stage combinationally. Full throughput is one word per cycle, with one cycle of latency.

## Interface
- `WIDTH`, default 32: data word width in bits.

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Clrn`  in  1  reset, synchronous, active-low.
- `Flush`  in  1  synchronous pipeline flush; discards all buffered words.
- `In_Valid`  in  1  upstream word present.
- `In_Data`  in  WIDTH  upstream word.
- `In_Ready`  out  1  buffer accepts a word this cycle; decoded from state flops only.
- `Out_Valid`  out  1  downstream word present.
- `Out_Data`  out  WIDTH  downstream word, driven from the main register.
- `Out_Ready`  in  1  downstream consumes the word this cycle.
- `Count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Handshake events:
  - `in_fire = In_Valid & In_Ready`.
  - `out_fire = Out_Valid & Out_Ready`.
  - `In_Valid` while `In_Ready=0` is ignored and has no side effects.
- Storage:
  - Main register `M` drives `Out_Data`.
  - Skid register `S` catches the word accepted on the cycle the downstream stalls.
- State machine, with `Count` equal to the state encoding:
  - **EMPTY (0)**:
    - `in_fire` → ONE, `M<=In_Data`.
  - **ONE (1)**:
    - `in_fire & out_fire` → ONE, `M<=In_Data`.
    - `in_fire & !out_fire` → FULL, `S<=In_Data`.
    - `!in_fire & out_fire` → EMPTY.
    - Otherwise hold.
  - **FULL (2)**:
    - `In_Ready=0`.
    - `out_fire` → ONE, `M<=S`.
    - Otherwise hold.
  - Encoding 3 is illegal; it recovers to EMPTY on the next edge.
- Outputs:
  - `Out_Valid = (state != EMPTY)`.
  - `In_Ready = (state != FULL)`.
- Ordering: words leave in acceptance order, and none is duplicated or dropped.
- Priority per edge: `Clrn=0` > `Flush=1` > normal operation.
  - Reset: state EMPTY, `M=0`, `S=0`.
  - Flush: state EMPTY; `M` and `S` hold their values; any `in_fire`/`out_fire` that cycle is discarded (the upstream must treat a flushed cycle as not accepted).
- `Out_Data` holds the last `M` value while `Out_Valid=0`.

## Timing
- Reset values: `Out_Valid=0`, `In_Ready=1`, `Count=0`, `Out_Data=0`.
- Latency:
  - A word accepted at edge k appears on `Out_Data` with `Out_Valid=1` after edge k.
  - A word leaving FULL via `S` appears one cycle after `M` drains.
- Throughput: one word per cycle in steady state with `Out_Ready=1`.
- Downstream stall:
  - `Out_Ready` falling while `In_Valid=1` costs exactly one extra accepted word (into `S`).
  - `In_Ready` falls the following cycle.
- Combinational paths:
  - No path from `Out_Ready` or `In_Valid` to `In_Ready`.
  - No path from any input to `Out_Valid` or `Out_Data`.
- Reset or flush mid-transfer takes effect at that edge; outputs show the EMPTY values from the next cycle.

## Structure
- Shared package `pipe_pkg`:
  - State enum `SB_EMPTY=2'd0`, `SB_ONE=2'd1`, `SB_FULL=2'd2`.
  - Default data width constant (32).
- Sub-module `dff_en_sync`: WIDTH-bit register with enable and synchronous active-low clear, instanced twice (for `M` and `S`).
- The FSM and the enable/mux logic live in the top level.

## Test plan
- **Reset:** `Clrn=0` for 2 cycles with random inputs → `Out_Valid=0`, `In_Ready=1`, `Count=0`, `Out_Data=0`.
- **Streaming:** 8 words 0x1..0x8 back-to-back with `Out_Ready=1` → outputs 0x1..0x8 on consecutive cycles, each one cycle after acceptance, `Count=1` throughout.
- **Stall:**
  - Stimulus: `Out_Ready=0` on the cycle after 0xA is accepted, with 0xB offered.
  - Required: 0xB is taken into `S`, then `Count=2` and `In_Ready=0`.
  - Stimulus: `Out_Ready` released.
  - Required: 0xA then 0xB delivered, and `In_Ready=1` again.
- **Full hold:** in FULL, `In_Valid=1` with 0xDEAD for 5 cycles → no acceptance; `Out_Data` stays at the `M` value.
- **Flush:** `Flush=1` in FULL with `in_fire` attempted → EMPTY next cycle, `Count=0`; the next word 0x55 is delivered, and nothing stale is.
- **Random soak:** 10k cycles of random valid/ready with scoreboard ordering checks, and `Count` matching the model every cycle.
